// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops the ps2_keyboard FIFO and turns set-2 scan bytes into clean make/break events.
// Optional KEY_REPEAT_EN: key_repeat pulses on each suppressed typematic make; otherwise tied low.
module ps2_key_ctrl #(
  parameter int CNT_W = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_break,
  output logic             key_held,
  output logic             key_repeat,
  output logic [CNT_W-1:0] press_count,
  output logic             err_ovf
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic [1:0] gap;
  logic [7:0] byte_r, held_code;
  logic byte_vld, held_ext, pop, is_ext, do_make, do_brk, same, expire;
  assign pop = kbd_ready && gap == 2'd0;
  always_comb begin
    is_ext = state == ST_EXT || state == ST_EXT_BRK;
    do_make = byte_vld && ((state == ST_IDLE &&
              !(byte_r inside {8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) ||
              (state == ST_EXT && byte_r != 8'hE0 && byte_r != 8'hF0));
    do_brk = byte_vld && (state == ST_BRK || state == ST_EXT_BRK);
    // compare against the held register, which survives breaks of other keys
    same = key_held && {is_ext, byte_r} == {held_ext, held_code};
    expire = state != ST_IDLE && timer == TW'(TIMEOUT_CYC - 1);
    nxt = !byte_vld ? (expire ? ST_IDLE : state) :
          state == ST_IDLE ? (byte_r == 8'hE0 ? ST_EXT : byte_r == 8'hF0 ? ST_BRK : ST_IDLE) :
          state == ST_EXT ? (byte_r == 8'hF0 ? ST_EXT_BRK : byte_r == 8'hE0 ? ST_EXT : ST_IDLE) :
          ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      kbd_nextdata_n <= 1'b1;
      gap <= '0;
      byte_r <= '0;
      byte_vld <= 1'b0;
      state <= ST_IDLE;
      timer <= '0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_make <= 1'b0;
      key_break <= 1'b0;
      key_held <= 1'b0;
      held_code <= '0;
      held_ext <= 1'b0;
      press_count <= '0;
      err_ovf <= 1'b0;
    end else begin
      kbd_nextdata_n <= !pop;
      gap <= pop ? 2'd2 : (gap != 2'd0 ? gap - 2'd1 : 2'd0);
      byte_vld <= pop;
      if (pop) byte_r <= kbd_data;
      state <= nxt;
      timer <= (byte_vld || state == ST_IDLE || expire) ? '0 : timer + 1'b1;
      key_make <= do_make && !same;
      key_break <= do_brk;
      if (do_make && !same) begin
        key_code <= byte_r;
        key_ext <= is_ext;
        key_held <= 1'b1;
        held_code <= byte_r;
        held_ext <= is_ext;
        press_count <= press_count + 1'b1;
      end
      if (do_brk) begin
        key_code <= byte_r;
        key_ext <= is_ext;
        if (same) key_held <= 1'b0;
      end
      if (kbd_overflow) err_ovf <= 1'b1;
    end
  end
`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) key_repeat <= !clr && do_make && same;
`else
  assign key_repeat = 1'b0;
`endif
endmodule
